// File: rtl/sonic_sensor_responder_if.sv
// Host-side signal bundle of the sonic sensor responder.
//   enable     : respond to triggers when 1 (host -> responder)
//   echo_len   : requested echo width in clk cycles (host -> responder)
//   busy       : responder is not idle (responder -> host)
//   trig_ok    : 1-cycle pulse, trigger accepted
//   trig_err   : 1-cycle pulse, trigger rejected for bad width
//   echo_done  : 1-cycle pulse on the last echo cycle
//   trig_count : running count of accepted triggers, wraps at 16 bits
// The shared sensor line itself stays a plain inout port on the responder.
interface sonic_sensor_responder_if;
  logic        enable;
  logic [31:0] echo_len;
  logic        busy;
  logic        trig_ok;
  logic        trig_err;
  logic        echo_done;
  logic [15:0] trig_count;

  modport master (
    output enable, echo_len,
    input  busy, trig_ok, trig_err, echo_done, trig_count
  );

  modport slave (
    input  enable, echo_len,
    output busy, trig_ok, trig_err, echo_done, trig_count
  );
endinterface

// File: rtl/sonic_sensor_responder.sv
// Sonic sensor responder: emulates an ultrasonic distance sensor on the
// single-wire trigger/echo line. Measures the host trigger pulse, waits a
// holdoff, drives an echo pulse whose width is the requested distance,
// then holds off further triggers for a recovery gap.
// Ports:
//   clk  : system clock
//   rst  : asynchronous reset, active low
//   sig  : shared sensor line; driven 1 only during ECHO, else released
//          (an external pull-down defines the idle level)
//   bus  : host bundle (enable, echo_len in; busy, pulses, trig_count out)
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a high level on the line while enabled
// S_TRIG_HIGH| measuring trigger high width
// S_ERR_WAIT | trigger too long, waiting for the line to fall
// S_HOLDOFF  | accepted, delay before echo start
// S_ECHO     | driving the line high for the latched length
// S_RECOVER  | dead time, line ignored
module sonic_sensor_responder #(
  parameter int unsigned TRIG_MIN = 200,
  parameter int unsigned TRIG_MAX = 1000,
  parameter int unsigned HOLDOFF  = 50000,
  parameter int unsigned ECHO_MAX = 1850000,
  parameter int unsigned RECOVER  = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  inout  wire                      sig,
  sonic_sensor_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG_HIGH = 3'd1,
    S_ERR_WAIT  = 3'd2,
    S_HOLDOFF   = 3'd3,
    S_ECHO      = 3'd4,
    S_RECOVER   = 3'd5
  } state_t;

  localparam logic [31:0] TRIG_MIN_C = TRIG_MIN;
  localparam logic [31:0] TRIG_MAX_C = TRIG_MAX;
  localparam logic [31:0] HOLDOFF_C  = HOLDOFF;
  localparam logic [31:0] ECHO_MAX_C = ECHO_MAX;
  localparam logic [31:0] RECOVER_C  = RECOVER;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [15:0] trig_count_q, trig_count_d;
  logic [31:0] len_clamped;
  logic        sync_1_q, sig_s;
  logic        trig_ok, trig_err, echo_done;

  // Two-flop synchroniser on the pin; the line is asynchronous to clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1_q <= 1'b0;
      sig_s    <= 1'b0;
    end else begin
      sync_1_q <= sig;
      sig_s    <= sync_1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      len_q        <= '0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      trig_count_q <= trig_count_d;
    end
  end

  // Zero would mean "no echo"; the sensor always answers with at least one cycle.
  always_comb begin
    len_clamped = bus.echo_len;
    if (bus.echo_len == 32'd0) begin
      len_clamped = 32'd1;
    end else if (bus.echo_len > ECHO_MAX_C) begin
      len_clamped = ECHO_MAX_C;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    trig_count_d = trig_count_q;
    trig_ok      = 1'b0;
    trig_err     = 1'b0;
    echo_done    = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The IDLE sample already counts as the first high cycle.
        if (bus.enable && sig_s) begin
          state_d = S_TRIG_HIGH;
          cnt_d   = 32'd1;
        end
      end

      S_TRIG_HIGH: begin
        if (sig_s) begin
          // This sample would make the width TRIG_MAX+1: reject now so a
          // fall on the following cycle cannot slip through unjudged.
          if (cnt_q >= TRIG_MAX_C) begin
            trig_err = 1'b1;
            state_d  = S_ERR_WAIT;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else if (cnt_q >= TRIG_MIN_C && cnt_q <= TRIG_MAX_C) begin
          trig_ok      = 1'b1;
          len_d        = len_clamped;
          trig_count_d = trig_count_q + 16'd1;
          state_d      = S_HOLDOFF;
          cnt_d        = '0;
        end else begin
          trig_err = 1'b1;
          state_d  = S_IDLE;
          cnt_d    = '0;
        end
      end

      S_ERR_WAIT: begin
        if (!sig_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      S_HOLDOFF: begin
        if (cnt_q >= HOLDOFF_C - 32'd1) begin
          state_d = S_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_ECHO: begin
        if (cnt_q >= len_q - 32'd1) begin
          echo_done = 1'b1;
          state_d   = S_RECOVER;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      S_RECOVER: begin
        if (cnt_q >= RECOVER_C - 32'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Drive is decoded straight from the state register so reset releases
  // the line without waiting for a clock.
  assign sig = (state_q == S_ECHO) ? 1'b1 : 1'bz;

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.trig_ok    = trig_ok;
  assign bus.trig_err   = trig_err;
  assign bus.echo_done  = echo_done;
  assign bus.trig_count = trig_count_q;

endmodule
